trigger_sequencer: RTL and testbench
====================================

TRIGGER_SEQUENCER -- requirements
Module: trigger_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of trigger channels (4 cameras + 1 IMU).
REQ-002 SHALL have parameter PER_W, default 28, period/frame counter width in bits.
REQ-003 SHALL have parameter DLY_W, default 12, per-channel delay width in bits.
REQ-004 SHALL have parameter PW_W, default 16, per-channel pulse-width width in bits.
REQ-005 SHALL have parameter DIV_W, default 4, per-channel frame-divider width in bits.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-008 SHALL have port enable, input, 1, a level that runs the sequencer.
REQ-009 SHALL have port mode, input, 2, the frame source: 00 continuous, 01 burst, 10 external sync, 11 treated as 00.
REQ-010 SHALL have port period, input, PER_W, frame period in clk cycles; values below 2 are treated as 2.
REQ-011 SHALL have port burst_len, input, 16, the number of frames per burst; 0 is treated as 1.
REQ-012 SHALL have port ext_sync, input, 1, an external frame strobe that is already synchronised to clk.
REQ-013 SHALL have port ch_delay, input, NUM_CH x DLY_W, the per-channel delay in cycles.
REQ-014 SHALL have port ch_width, input, NUM_CH x PW_W, the per-channel pulse width; 0 is treated as 1.
REQ-015 SHALL have port ch_div, input, NUM_CH x DIV_W, so that a channel fires every (ch_div+1)th frame.
REQ-016 SHALL have port ch_mask, input, NUM_CH, per-channel enables.
REQ-017 SHALL have port trig_out, output, NUM_CH, the per-channel trigger pulses.
REQ-018 SHALL have port frame_start, output, 1, a one-cycle strobe at each frame start.
REQ-019 SHALL have port frame_cnt, output, 32, the number of frames since run start.
REQ-020 SHALL have port busy, output, 1, high in the ARMED and RUN states or while any trig_out is high.
REQ-021 SHALL have port done, output, 1, high in the DONE state.

Function
REQ-022 SHALL implement the states IDLE, ARMED, RUN and DONE.
REQ-023 SHALL handle the IDLE state as follows: on enable rising edge, go to ARMED if mode is 10, else go to RUN with the period counter at 0.
REQ-024 SHALL, in the RUN state, assert frame_start in the cycle the period counter equals 0; the counter wraps from period-1 to 0.
REQ-025 SHALL, in the ARMED and RUN states with mode 10, assert frame_start in the cycle after each ext_sync rising edge and run no internal period.
REQ-026 SHALL, in burst mode, go from RUN to DONE on the cycle after the last pulse of frame burst_len ends; DONE holds until enable is deasserted, then goes to IDLE.
REQ-027 SHALL, when enable is deasserted in any state, go to IDLE on the next cycle and clear all trig_out, counters and frame_cnt.
REQ-028 SHALL sample period, ch_delay, ch_width, ch_div and ch_mask into shadow registers at each frame_start; a mid-frame register change SHALL take effect at the next frame only.
REQ-029 SHALL, for a channel fired in the frame_start cycle T, drive trig_out[i] high from cycle T+1+ch_delay[i] for exactly ch_width[i] cycles.
REQ-030 SHALL fire channel i only when ch_mask[i]=1 and its per-channel divider count equals 0; the divider counts frames modulo ch_div[i]+1 and resets to 0 at run start.
REQ-031 SHALL, on a new frame_start while channel i is still delaying or pulsing, restart the channel from the new frame and truncate the old pulse.
REQ-032 SHALL increment frame_cnt on each frame_start and saturate it at all-ones.
REQ-033 SHALL give an ext_sync edge in the same cycle as enable deassertion lower priority, so no frame starts.

Reset
REQ-034 SHALL, while rst is asserted, set state to IDLE and set trig_out, frame_start, frame_cnt, busy, done and all counters to 0.
REQ-035 SHALL load the shadow registers with period 6_666_666, delay 0, width 2000, div 0 and mask all-ones during reset.
REQ-036 SHALL, on a reset asserted mid-pulse, drive trig_out low in the cycle after the reset clock edge.

Configuration
REQ-037 SHALL, with TRIG_OVERRUN_DET_EN defined, add an output overrun_err (width NUM_CH), sticky per channel, set when REQ-031 truncation occurs and cleared by rst or on entry to IDLE.
REQ-038 SHALL, without TRIG_OVERRUN_DET_EN, omit the overrun_err port and logic, with all other behaviour identical.

Structure
REQ-039 SHALL place the state enum, the mode encoding and the default constants in package trigger_pkg.
REQ-040 SHALL implement each channel's divider, delay and width counter in sub-module trigger_channel, instantiated NUM_CH times.

Verification
REQ-041 SHALL verify continuous mode: with period=100, delay=0, width=10 and div=0, frame_start occurs every 100 cycles and trig_out rises 1 cycle after frame_start and is high for 10 cycles.
REQ-042 SHALL verify per-channel delay and divider: with delays {0,3,7,255,0} and ch_div[4]=1, the rises are skewed by exactly 0/3/7/255 cycles and channel 4 fires on frames 0, 2, 4, ....
REQ-043 SHALL verify burst mode: with burst_len=3 and period=50, there are exactly 3 frame_start pulses, done rises after the third pulse ends, and deasserting enable returns done to 0.
REQ-044 SHALL verify external sync mode: with mode=10 and ext_sync edges at cycles 20 and 95, frame_start occurs at cycles 21 and 96 and there are no internal frames.
REQ-045 SHALL verify overrun handling: with period=20, delay=15 and width=10 with TRIG_OVERRUN_DET_EN defined, the pulse is truncated at the next frame and overrun_err[0]=1.
REQ-046 SHALL verify mid-frame changes and reset: changing width mid-frame leaves the current pulse width unchanged, and asserting rst mid-pulse gives all outputs 0 on the next cycle.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared encodings and power-on defaults for the trigger sequencer.
package trigger_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] MODE_CONT  = 2'b00;
  localparam logic [1:0] MODE_BURST = 2'b01;
  localparam logic [1:0] MODE_EXT   = 2'b10;

  localparam int unsigned DEF_PERIOD = 6_666_666;
  localparam int unsigned DEF_DELAY  = 0;
  localparam int unsigned DEF_WIDTH  = 2000;
  localparam int unsigned DEF_DIV    = 0;

  // Encoding 11 is reserved and behaves as continuous.
  function automatic logic [1:0] mode_norm(input logic [1:0] m);
    return (m == 2'b11) ? MODE_CONT : m;
  endfunction

endpackage

// File: rtl/trigger_channel.sv
// One trigger channel: frame divider, delay and pulse-width timing with
// delay/width/mask captured at each frame start.
module trigger_channel
  import trigger_pkg::*;
#(
  parameter int DLY_W = 12,
  parameter int PW_W  = 16,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             fs_i,
  input  logic             mask_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DLY_W-1:0] dly_i,
  input  logic [PW_W-1:0]  wid_i,
  output logic             trig_o,
  output logic             act_nxt_o,
  output logic             ovr_o
);

  localparam int CW = ((DLY_W > PW_W) ? DLY_W : PW_W) + 1;

  logic             act_q, act_d;
  logic [CW-1:0]    cnt_q, cnt_d, end_cnt;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [PW_W-1:0]  wid_q, wid_d;
  logic             msk_q, msk_d;
  logic             fire;

  assign fire    = fs_i & mask_i & (div_q == '0);
  // cnt runs 0..dly+wid-1 from the cycle after the frame start
  assign end_cnt = CW'(dly_q) + CW'(wid_q) - CW'(1);

  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    div_d = div_q;
    dly_d = dly_q;
    wid_d = wid_q;
    msk_d = msk_q;
    if (clr_i) begin
      act_d = 1'b0;
      cnt_d = '0;
      div_d = '0;
    end else if (fs_i) begin
      dly_d = dly_i;
      wid_d = (wid_i == '0) ? PW_W'(1) : wid_i;
      msk_d = mask_i;
      div_d = (div_q >= div_i) ? '0 : div_q + DIV_W'(1);
      act_d = fire;
      cnt_d = '0;
    end else if (act_q) begin
      if (cnt_q == end_cnt) act_d = 1'b0;
      else                  cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 1'b0;
      cnt_q <= '0;
      div_q <= DIV_W'(DEF_DIV);
      dly_q <= DLY_W'(DEF_DELAY);
      wid_q <= PW_W'(DEF_WIDTH);
      msk_q <= 1'b1;
    end else begin
      act_q <= act_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      dly_q <= dly_d;
      wid_q <= wid_d;
      msk_q <= msk_d;
    end
  end

  assign trig_o    = act_q & msk_q & (cnt_q >= CW'(dly_q));
  assign act_nxt_o = act_d;
  assign ovr_o     = fs_i & act_q & ~clr_i;

endmodule

// File: rtl/trigger_sequencer.sv
// Multi-channel camera/IMU trigger sequencer: continuous, burst and external-sync
// framing. Define TRIG_OVERRUN_DET_EN to add the sticky overrun_err output.
module trigger_sequencer
  import trigger_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int PER_W  = 28,
  parameter int DLY_W  = 12,
  parameter int PW_W   = 16,
  parameter int DIV_W  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [1:0]                    mode,
  input  logic [PER_W-1:0]              period,
  input  logic [15:0]                   burst_len,
  input  logic                          ext_sync,
  input  logic [NUM_CH-1:0][DLY_W-1:0]  ch_delay,
  input  logic [NUM_CH-1:0][PW_W-1:0]   ch_width,
  input  logic [NUM_CH-1:0][DIV_W-1:0]  ch_div,
  input  logic [NUM_CH-1:0]             ch_mask,
  output logic [NUM_CH-1:0]             trig_out,
  output logic                          frame_start,
  output logic [31:0]                   frame_cnt,
  output logic                          busy,
  output logic                          done
`ifdef TRIG_OVERRUN_DET_EN
  , output logic [NUM_CH-1:0]           overrun_err
`endif
);

  logic [1:0]        state_q, state_d, mode_n;
  logic              en_q, ext_q, pend_q, pend_d;
  logic [PER_W-1:0]  per_q, per_d, per_sh_q, per_sh_d, per_eff;
  logic [31:0]       fcnt_q, fcnt_d;
  logic [15:0]       bcnt_q, bcnt_d, burst_eff;
  logic              run_start, fs, clr, burst_end;
  logic [NUM_CH-1:0] act_nxt, ovr_hit;

  assign mode_n    = mode_norm(mode);
  assign per_eff   = (period < PER_W'(2)) ? PER_W'(2) : period;
  assign burst_eff = (burst_len == 16'd0) ? 16'd1 : burst_len;
  assign run_start = (state_q == ST_IDLE) & enable & ~en_q;
  assign burst_end = (mode_n == MODE_BURST) & (bcnt_q >= burst_eff);
  assign clr       = ~enable | run_start;

  // Gating on enable gives a coincident disable priority over any frame source.
  assign fs = ~rst & enable &
              (((state_q == ST_RUN) & (mode_n != MODE_EXT) & (per_q == '0) & ~burst_end) |
               (((state_q == ST_ARMED) | (state_q == ST_RUN)) & (mode_n == MODE_EXT) & pend_q));

  always_comb begin
    state_d  = state_q;
    per_d    = per_q;
    fcnt_d   = fcnt_q;
    bcnt_d   = bcnt_q;
    per_sh_d = per_sh_q;
    pend_d   = enable & ext_sync & ~ext_q;
    if (fs) begin
      per_sh_d = per_eff;
      if (fcnt_q != '1) fcnt_d = fcnt_q + 32'd1;
      if (bcnt_q != '1) bcnt_d = bcnt_q + 16'd1;
    end
    case (state_q)
      ST_IDLE: if (run_start) begin
        state_d = (mode_n == MODE_EXT) ? ST_ARMED : ST_RUN;
        per_d   = '0;
        fcnt_d  = '0;
        bcnt_d  = '0;
      end
      ST_ARMED: if (fs || mode_n != MODE_EXT) state_d = ST_RUN;
      ST_RUN: begin
        if (mode_n == MODE_EXT)                   per_d = '0;
        else if (per_q >= per_sh_q - PER_W'(1))   per_d = '0;
        else                                      per_d = per_q + PER_W'(1);
        // finish once the last burst frame has drained from every channel
        if (burst_end && act_nxt == '0) state_d = ST_DONE;
      end
      default: ;
    endcase
    if (!enable) begin
      state_d = ST_IDLE;
      per_d   = '0;
      fcnt_d  = '0;
      bcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      ext_q    <= 1'b0;
      pend_q   <= 1'b0;
      per_q    <= '0;
      fcnt_q   <= '0;
      bcnt_q   <= '0;
      per_sh_q <= PER_W'(DEF_PERIOD);
    end else begin
      state_q  <= state_d;
      en_q     <= enable;
      ext_q    <= ext_sync;
      pend_q   <= pend_d;
      per_q    <= per_d;
      fcnt_q   <= fcnt_d;
      bcnt_q   <= bcnt_d;
      per_sh_q <= per_sh_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    trigger_channel #(
      .DLY_W(DLY_W),
      .PW_W (PW_W),
      .DIV_W(DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (clr),
      .fs_i     (fs),
      .mask_i   (ch_mask[g]),
      .div_i    (ch_div[g]),
      .dly_i    (ch_delay[g]),
      .wid_i    (ch_width[g]),
      .trig_o   (trig_out[g]),
      .act_nxt_o(act_nxt[g]),
      .ovr_o    (ovr_hit[g])
    );
  end

`ifdef TRIG_OVERRUN_DET_EN
  logic [NUM_CH-1:0] ovr_q;
  always_ff @(posedge clk) begin
    if (rst || !enable) ovr_q <= '0;
    else                ovr_q <= ovr_q | ovr_hit;
  end
  assign overrun_err = ovr_q;
`else
  logic unused_ovr;
  assign unused_ovr = ^ovr_hit;
`endif

  assign frame_start = fs;
  assign frame_cnt   = fcnt_q;
  assign busy        = (state_q == ST_ARMED) | (state_q == ST_RUN) | (|trig_out);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_trigger_sequencer.sv
// Scoreboard bench: each scenario queues expected frame/edge cycles, a negedge
// monitor pops and compares them as the sequencer produces them.
module tb_trigger_sequencer;

  localparam int NC = 5;

  logic                clk = 1'b0;
  logic                rst, enable, ext_sync;
  logic [1:0]          mode;
  logic [27:0]         period;
  logic [15:0]         burst_len;
  logic [NC-1:0][11:0] ch_delay;
  logic [NC-1:0][15:0] ch_width;
  logic [NC-1:0][3:0]  ch_div;
  logic [NC-1:0]       ch_mask;
  logic [NC-1:0]       trig_out;
  logic                frame_start, busy, done;
  logic [31:0]         frame_cnt;
`ifdef TRIG_OVERRUN_DET_EN
  logic [NC-1:0]       overrun_err;
`endif

  trigger_sequencer dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .period(period),
    .burst_len(burst_len), .ext_sync(ext_sync), .ch_delay(ch_delay),
    .ch_width(ch_width), .ch_div(ch_div), .ch_mask(ch_mask),
    .trig_out(trig_out), .frame_start(frame_start), .frame_cnt(frame_cnt),
    .busy(busy), .done(done)
`ifdef TRIG_OVERRUN_DET_EN
    , .overrun_err(overrun_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  int fs_q[$];
  int rise_q[NC][$];
  int fall_q[NC][$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  // scoreboard monitor
  initial begin
    logic [NC-1:0] prev_t;
    int e;
    prev_t = '0;
    forever begin
      @(negedge clk);
      if (frame_start === 1'b1) begin
        n_checks++;
        if (fs_q.size() == 0) begin
          n_err++;
          $display("FAIL frame_start: unexpected at cycle %0d, none queued", cyc);
        end else begin
          e = fs_q.pop_front();
          if (e != cyc) begin
            n_err++;
            $display("FAIL frame_start: at cycle %0d, expected cycle %0d", cyc, e);
          end
        end
      end
      for (int i = 0; i < NC; i++) begin
        if (trig_out[i] === 1'b1 && prev_t[i] === 1'b0) begin
          n_checks++;
          if (rise_q[i].size() == 0) begin
            n_err++;
            $display("FAIL trig_rise[%0d]: unexpected at cycle %0d", i, cyc);
          end else begin
            e = rise_q[i].pop_front();
            if (e != cyc) begin
              n_err++;
              $display("FAIL trig_rise[%0d]: at cycle %0d, expected cycle %0d", i, cyc, e);
            end
          end
        end
        if (trig_out[i] === 1'b0 && prev_t[i] === 1'b1) begin
          n_checks++;
          if (fall_q[i].size() == 0) begin
            n_err++;
            $display("FAIL trig_fall[%0d]: unexpected at cycle %0d", i, cyc);
          end else begin
            e = fall_q[i].pop_front();
            if (e != cyc) begin
              n_err++;
              $display("FAIL trig_fall[%0d]: at cycle %0d, expected cycle %0d", i, cyc, e);
            end
          end
        end
      end
      prev_t = trig_out;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step(1);
  endtask

  function automatic int pending();
    int n = fs_q.size();
    for (int i = 0; i < NC; i++) n += rise_q[i].size() + fall_q[i].size();
    return n;
  endfunction

  task automatic set_cfg(input int dly, input int wid, input int dv, input logic [NC-1:0] msk);
    for (int i = 0; i < NC; i++) begin
      ch_delay[i] = 12'(dly);
      ch_width[i] = 16'(wid);
      ch_div[i]   = 4'(dv);
    end
    ch_mask = msk;
  endtask

  task automatic test_reset();
    step(2);
    n_checks++; if (trig_out !== '0)    begin n_err++; $display("FAIL reset_trig: got %b expected 0", trig_out); end
    n_checks++; if (frame_start !== 0)  begin n_err++; $display("FAIL reset_fs: got %b expected 0", frame_start); end
    n_checks++; if (frame_cnt !== 0)    begin n_err++; $display("FAIL reset_fcnt: got %0d expected 0", frame_cnt); end
    n_checks++; if (busy !== 0)         begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 0)         begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_continuous();
    int s;
    set_cfg(0, 10, 0, 5'b11111);
    mode = 2'b00; period = 28'd100;
    s = cyc + 1; enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      fs_q.push_back(s + 100*j);
      for (int i = 0; i < NC; i++) begin
        rise_q[i].push_back(s + 1 + 100*j);
        fall_q[i].push_back(s + 11 + 100*j);
      end
    end
    wait_until(s + 150);
    n_checks++; if (frame_cnt !== 32'd2) begin n_err++; $display("FAIL cont_fcnt: got %0d expected 2", frame_cnt); end
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL cont_busy: got %b expected 1", busy); end
    wait_until(s + 249);
    enable = 1'b0;
    step(1);
    n_checks++; if (frame_cnt !== 0) begin n_err++; $display("FAIL cont_clear_fcnt: got %0d expected 0", frame_cnt); end
    n_checks++; if (busy !== 0) begin n_err++; $display("FAIL cont_clear_busy: got %b expected 0", busy); end
    step(60);
    n_checks++; if (pending() != 0) begin n_err++; $display("FAIL cont_drain: got %0d expected 0 events outstanding", pending()); end
  endtask

  task automatic test_delay_div();
    int s;
    int d[NC] = '{0, 3, 7, 255, 0};
    set_cfg(0, 4, 0, 5'b11111);
    for (int i = 0; i < NC; i++) ch_delay[i] = 12'(d[i]);
    ch_div[4] = 4'd1;
    mode = 2'b00; period = 28'd300;
    s = cyc + 1; enable = 1'b1;
    for (int j = 0; j < 4; j++) begin
      fs_q.push_back(s + 300*j);
      for (int i = 0; i < NC; i++) begin
        if (i != 4 || (j % 2) == 0) begin
          rise_q[i].push_back(s + 1 + d[i] + 300*j);
          fall_q[i].push_back(s + 5 + d[i] + 300*j);
        end
      end
    end
    wait_until(s + 1165);
    n_checks++; if (frame_cnt !== 32'd4) begin n_err++; $display("FAIL div_fcnt: got %0d expected 4", frame_cnt); end
    enable = 1'b0;
    step(5);
    n_checks++; if (pending() != 0) begin n_err++; $display("FAIL div_drain: got %0d expected 0 events outstanding", pending()); end
  endtask

  task automatic test_burst();
    int s;
    set_cfg(0, 10, 0, 5'b00001);
    mode = 2'b01; period = 28'd50; burst_len = 16'd3;
    s = cyc + 1; enable = 1'b1;
    for (int j = 0; j < 3; j++) begin
      fs_q.push_back(s + 50*j);
      rise_q[0].push_back(s + 1 + 50*j);
      fall_q[0].push_back(s + 11 + 50*j);
    end
    wait_until(s + 110);
    n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL burst_done_early: got %b expected 0", done); end
    step(1);
    n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL burst_done: got %b expected 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL burst_busy: got %b expected 0", busy); end
    wait_until(s + 220);
    n_checks++; if (frame_cnt !== 32'd3) begin n_err++; $display("FAIL burst_fcnt: got %0d expected 3", frame_cnt); end
    n_checks++; if (done !== 1'b1) begin n_err++; $display("FAIL burst_done_hold: got %b expected 1", done); end
    enable = 1'b0;
    step(1);
    n_checks++; if (done !== 1'b0) begin n_err++; $display("FAIL burst_done_clear: got %b expected 0", done); end
    step(3);
    n_checks++; if (pending() != 0) begin n_err++; $display("FAIL burst_drain: got %0d expected 0 events outstanding", pending()); end
  endtask

  task automatic test_ext_sync();
    int r;
    set_cfg(2, 3, 0, 5'b00001);
    mode = 2'b10; period = 28'd10;
    r = cyc; enable = 1'b1;
    wait_until(r + 5);
    n_checks++; if (busy !== 1'b1) begin n_err++; $display("FAIL ext_armed_busy: got %b expected 1", busy); end
    wait_until(r + 20);
    ext_sync = 1'b1;
    fs_q.push_back(r + 21); rise_q[0].push_back(r + 24); fall_q[0].push_back(r + 27);
    step(2); ext_sync = 1'b0;
    wait_until(r + 95);
    ext_sync = 1'b1;
    fs_q.push_back(r + 96); rise_q[0].push_back(r + 99); fall_q[0].push_back(r + 102);
    step(2); ext_sync = 1'b0;
    wait_until(r + 150);
    n_checks++; if (frame_cnt !== 32'd2) begin n_err++; $display("FAIL ext_fcnt: got %0d expected 2", frame_cnt); end
    // edge coincident with disable must not start a frame
    ext_sync = 1'b1; enable = 1'b0;
    step(3);
    n_checks++; if (frame_cnt !== 0) begin n_err++; $display("FAIL ext_disable_fcnt: got %0d expected 0", frame_cnt); end
    ext_sync = 1'b0;
    step(2);
    n_checks++; if (pending() != 0) begin n_err++; $display("FAIL ext_drain: got %0d expected 0 events outstanding", pending()); end
  endtask

  task automatic test_overrun();
    int s;
    set_cfg(15, 10, 0, 5'b00001);
    mode = 2'b00; period = 28'd20;
    s = cyc + 1; enable = 1'b1;
    for (int j = 0; j < 3; j++) fs_q.push_back(s + 20*j);
    rise_q[0].push_back(s + 16); fall_q[0].push_back(s + 21);
    rise_q[0].push_back(s + 36); fall_q[0].push_back(s + 41);
    wait_until(s + 30);
`ifdef TRIG_OVERRUN_DET_EN
    n_checks++; if (overrun_err !== 5'b00001) begin n_err++; $display("FAIL overrun_set: got %b expected 00001", overrun_err); end
`endif
    n_checks++; if (trig_out[0] !== 1'b0) begin n_err++; $display("FAIL overrun_trunc: got %b expected 0", trig_out[0]); end
    wait_until(s + 45);
    enable = 1'b0;
    step(1);
    n_checks++; if (trig_out !== '0) begin n_err++; $display("FAIL overrun_clear_trig: got %b expected 0", trig_out); end
`ifdef TRIG_OVERRUN_DET_EN
    n_checks++; if (overrun_err !== '0) begin n_err++; $display("FAIL overrun_clear: got %b expected 0", overrun_err); end
`endif
    step(30);
    n_checks++; if (pending() != 0) begin n_err++; $display("FAIL overrun_drain: got %0d expected 0 events outstanding", pending()); end
  endtask

  task automatic test_midframe_reset();
    int s;
    set_cfg(0, 10, 0, 5'b00001);
    mode = 2'b00; period = 28'd100;
    s = cyc + 1; enable = 1'b1;
    fs_q.push_back(s); rise_q[0].push_back(s + 1); fall_q[0].push_back(s + 11);
    fs_q.push_back(s + 100); rise_q[0].push_back(s + 101); fall_q[0].push_back(s + 111);
    wait_until(s + 3);
    ch_width[0] = 16'd30;
    wait_until(s + 110);
    n_checks++; if (trig_out[0] !== 1'b1) begin n_err++; $display("FAIL mid_wide_pulse: got %b expected 1", trig_out[0]); end
    rst = 1'b1;
    step(1);
    n_checks++; if (trig_out !== '0)   begin n_err++; $display("FAIL rst_trig: got %b expected 0", trig_out); end
    n_checks++; if (frame_start !== 0) begin n_err++; $display("FAIL rst_fs: got %b expected 0", frame_start); end
    n_checks++; if (frame_cnt !== 0)   begin n_err++; $display("FAIL rst_fcnt: got %0d expected 0", frame_cnt); end
    n_checks++; if (busy !== 0)        begin n_err++; $display("FAIL rst_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 0)        begin n_err++; $display("FAIL rst_done: got %b expected 0", done); end
    rst = 1'b0; enable = 1'b0;
    step(5);
    n_checks++; if (pending() != 0) begin n_err++; $display("FAIL mid_drain: got %0d expected 0 events outstanding", pending()); end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; ext_sync = 1'b0; mode = 2'b00;
    period = 28'd100; burst_len = 16'd1;
    set_cfg(0, 10, 0, 5'b11111);
    test_reset();
    test_continuous();
    test_delay_div();
    test_burst();
    test_ext_sync();
    test_overrun();
    test_midframe_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
